halut_lut_loader: RTL and testbench
===================================

# halut_lut_loader

Writer side of the decoder LUT storage: accepts a linear stream of precomputed LUT entries and scatters them into the per-decoder-unit LUT memories that the decoder units read during inference. It generates the (m, c, k) write coordinates, selects the owning decoder unit, and signals completion. It sits between the host/DMA stream and the DecoderUnits LUT write ports.

## Interface
Parameters:
- K, 16, prototypes per codebook (from halut_pkg, fixed)
- C, `NUM_C` (32), codebooks
- M, `NUM_M` (32), output columns; M must be a multiple of DecoderUnits
- DataTypeWidth, `DATA_WIDTH` (16), LUT entry width
- DecoderUnits, `NUM_DECODER_UNITS` (16), number of LUT memories
- Derived: MPerUnit = M/DecoderUnits; AddrWidth = $clog2(MPerUnit*C*K) (10 at defaults)

Ports:
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin a full LUT load (sampled in IDLE only)
- abort_i  in  1  cancel the load in progress
- lut_valid_i  in  1  stream beat valid
- lut_data_i  in  DataTypeWidth  LUT entry
- lut_ready_o  out  1  beat accepted when valid & ready
- wr_en_o  out  DecoderUnits  one-hot write enable
- wr_addr_o  out  AddrWidth  address within selected unit
- wr_data_o  out  DataTypeWidth  write data
- busy_o  out  1  high in LOAD
- done_o  out  1  one-cycle pulse after last write
- checksum_o  out  32  running sum of loaded entries (see Configuration)

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: lut_ready_o=0. start_i=1 -> LOAD; counters k, c, m and checksum cleared.
- LOAD: lut_ready_o=1 (memories never back-pressure). Each accepted beat writes LUT[m][c][k]; order k fastest, then c, then m.
- Unit select = m % DecoderUnits; m_local = m / DecoderUnits; wr_addr_o = (m_local*C + c)*K + k.
- Counter advance: k wraps 15->0 incrementing c; c wraps C-1->0 incrementing m.
- Beat at (M-1, C-1, 15) -> DONE; counters return to 0.
- DONE: done_o=1 for exactly one cycle, lut_ready_o=0, then IDLE.
- abort_i in LOAD -> IDLE next cycle, no done_o; a beat presented in the same cycle as abort_i is not accepted (ready forced low). abort_i in IDLE/DONE ignored.
- start_i in LOAD or DONE ignored.
- lut_valid_i=0 in LOAD: no write, counters hold.

## Timing
- Reset values: lut_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0, done_o=0, checksum_o=0; FSM in IDLE.
- start_i high at cycle t -> busy_o and lut_ready_o high from t+1.
- Write outputs registered: beat accepted at cycle t -> wr_en_o/addr/data valid at t+1 for one cycle; wr_en_o=0 otherwise.
- Last beat at t -> final write at t+1, done_o at t+1, busy_o low at t+1, IDLE at t+2; start_i at t+2 accepted.
- Full load at 100% valid: M*C*K accepted cycles (16384 at defaults) + 1 start + 1 done.
- Reset mid-load: immediate return to IDLE with all outputs at reset values; partial LUT contents undefined.

## Configuration
- HALUT_LUT_LOADER_CHECKSUM_EN defined: checksum_o = 32-bit wrapping sum of lut_data_i (zero-extended) over accepted beats of the current load; cleared on start; updated with the registered write (same cycle as wr_en_o); held after done until next start.
- Undefined: checksum logic absent, checksum_o tied to 0.

## Test plan
- Reset mid-load after 100 beats, then start -> first write at wr_addr_o=0, wr_en_o=16'h0001; no done_o until full 16384 beats.
- Full load, data = beat index, valid always high -> beat 0: unit 0 addr 0; beat 16: unit 0 addr 16 (c=1); beat 512: unit 1 addr 0 (m=1); beat 8192: unit 0 addr 512 (m=16); done_o exactly once, at cycle after beat 16383.
- Random valid gaps (50%) -> identical memory image to gap-free run; counters hold on idle cycles.
- abort_i after 1000 beats with valid high -> beat on abort cycle not accepted, busy_o low next cycle, done_o never asserted; new start restarts at addr 0.
- start_i pulsed during LOAD and DONE -> ignored; no counter reset.
- With HALUT_LUT_LOADER_CHECKSUM_EN, all data 16'hFFFF -> checksum_o = 16384*65535 = 32'h3FFF_C000 at done; without macro, checksum_o = 0 throughout.

Source files
------------

// File: rtl/halut_lut_loader.sv
// Decoder LUT writer: scatters a linear stream of LUT entries into per-unit LUT memories.
// Optional running checksum of loaded entries enabled by `define HALUT_LUT_LOADER_CHECKSUM_EN.
module halut_lut_loader #(
    parameter int unsigned K             = 16,
    parameter int unsigned C             = 32,
    parameter int unsigned M             = 32,
    parameter int unsigned DataTypeWidth = 16,
    parameter int unsigned DecoderUnits  = 16,
    parameter int unsigned MPerUnit      = M / DecoderUnits,
    parameter int unsigned AddrWidth     = $clog2(MPerUnit * C * K)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     lut_valid_i,
    input  logic [DataTypeWidth-1:0] lut_data_i,
    output logic                     lut_ready_o,
    output logic [DecoderUnits-1:0]  wr_en_o,
    output logic [AddrWidth-1:0]     wr_addr_o,
    output logic [DataTypeWidth-1:0] wr_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [31:0]              checksum_o
);

    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned MW = (M > 1) ? $clog2(M) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DecoderUnits-1:0] UNIT0 = {{(DecoderUnits-1){1'b0}}, 1'b1};

    logic [1:0]               state_q, state_d;
    logic [KW-1:0]            k_q, k_d;
    logic [CW-1:0]            c_q, c_d;
    logic [MW-1:0]            m_q, m_d;
    logic [DecoderUnits-1:0]  wr_en_q, wr_en_d;
    logic [AddrWidth-1:0]     wr_addr_q, wr_addr_d;
    logic [DataTypeWidth-1:0] wr_data_q, wr_data_d;
    logic                     accept_s;
    logic                     k_wrap_s;
    logic                     c_wrap_s;
    logic                     last_s;

    // An abort in the same cycle as a beat kills the handshake so the beat is not consumed.
    assign accept_s = (state_q == LOAD) && lut_valid_i && !abort_i;
    assign k_wrap_s = (k_q == KW'(K - 1));
    assign c_wrap_s = (c_q == CW'(C - 1));
    assign last_s   = k_wrap_s && c_wrap_s && (m_q == MW'(M - 1));

    assign lut_ready_o = (state_q == LOAD) && !abort_i;
    assign busy_o      = (state_q == LOAD);
    assign done_o      = (state_q == DONE);
    assign wr_en_o     = wr_en_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;

    // Next-state, coordinate counters and write-port staging.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        c_d       = c_q;
        m_d       = m_q;
        wr_en_d   = {DecoderUnits{1'b0}};
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    k_d     = {KW{1'b0}};
                    c_d     = {CW{1'b0}};
                    m_d     = {MW{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (lut_valid_i) begin
                    // Column m lives in unit m % DecoderUnits, slot m / DecoderUnits.
                    wr_en_d   = UNIT0 << (32'(m_q) % DecoderUnits);
                    wr_addr_d = AddrWidth'(((32'(m_q) / DecoderUnits) * C + 32'(c_q)) * K + 32'(k_q));
                    wr_data_d = lut_data_i;
                    if (last_s) begin
                        state_d = DONE;
                        k_d     = {KW{1'b0}};
                        c_d     = {CW{1'b0}};
                        m_d     = {MW{1'b0}};
                    end else if (k_wrap_s) begin
                        k_d = {KW{1'b0}};
                        if (c_wrap_s) begin
                            c_d = {CW{1'b0}};
                            m_d = m_q + MW'(1);
                        end else begin
                            c_d = c_q + CW'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    state_d = LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            k_q       <= {KW{1'b0}};
            c_q       <= {CW{1'b0}};
            m_q       <= {MW{1'b0}};
            wr_en_q   <= {DecoderUnits{1'b0}};
            wr_addr_q <= {AddrWidth{1'b0}};
            wr_data_q <= {DataTypeWidth{1'b0}};
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            c_q       <= c_d;
            m_q       <= m_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef HALUT_LUT_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    // Running sum, cleared on start and held after the load completes.
    always_comb begin
        if ((state_q == IDLE) && start_i) begin
            checksum_d = 32'h0000_0000;
        end else if (accept_s) begin
            checksum_d = checksum_q + 32'(lut_data_i);
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register, lands in the same cycle as the corresponding write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            checksum_q <= 32'h0000_0000;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_halut_lut_loader.sv
// Scoreboard bench for halut_lut_loader: driver pushes expected writes, a negedge monitor pops and compares.
module tb_halut_lut_loader;
    localparam int K     = 16;
    localparam int C     = 32;
    localparam int M     = 32;
    localparam int DW    = 16;
    localparam int DU    = 16;
    localparam int AW    = 10;
    localparam int TOTAL = M * C * K;

`ifdef HALUT_LUT_LOADER_CHECKSUM_EN
    localparam logic [31:0] CK_100  = 32'd4950;
    localparam logic [31:0] CK_FULL = 32'h07FF_E000;
`else
    localparam logic [31:0] CK_100  = 32'h0000_0000;
    localparam logic [31:0] CK_FULL = 32'h0000_0000;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          abort_i;
    logic          lut_valid_i;
    logic [DW-1:0] lut_data_i;
    logic          lut_ready_o;
    logic [DU-1:0] wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic          busy_o;
    logic          done_o;
    logic [31:0]   checksum_o;

    halut_lut_loader dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .lut_valid_i (lut_valid_i),
        .lut_data_i  (lut_data_i),
        .lut_ready_o (lut_ready_o),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .checksum_o  (checksum_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [DU-1:0] en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    int            n_cmp    = 0;
    int            n_err    = 0;
    int            cyc      = 0;
    int            done_cnt = 0;
    int            done_cyc = -1;
    int            last_acc = -1;
    int            img_sel  = 0;
    int            wr_cnt   = 0;
    logic [DW-1:0] img_a[TOTAL];
    logic [DW-1:0] img_b[TOTAL];

    int            spot_idx[4]  = '{0, 16, 512, 8192};
    logic [DU-1:0] spot_en[4]   = '{16'h0001, 16'h0001, 16'h0002, 16'h0001};
    logic [AW-1:0] spot_addr[4] = '{10'd0, 10'd16, 10'd0, 10'd512};

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic exp_t model(int i, logic [DW-1:0] d);
        exp_t          e;
        logic [DU-1:0] one;
        int            m;
        int            c;
        int            k;
        one    = 16'h0001;
        m      = i / (C * K);
        c      = (i / K) % C;
        k      = i % K;
        e.en   = one << (m % DU);
        e.addr = AW'(((m / DU) * C + c) * K + k);
        e.data = d;
        return e;
    endfunction

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: pop the expected write on every asserted wr_en_o; record done pulses and memory image.
    always @(negedge clk_i) begin
        exp_t e;
        int   u;
        if (!rst_i) begin
            if (wr_en_o != '0) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got en=%h addr=%0d data=%h, want no write", wr_en_o, wr_addr_o, wr_data_o);
                end else begin
                    e = sb_q.pop_front();
                    if (wr_en_o !== e.en || wr_addr_o !== e.addr || wr_data_o !== e.data) begin
                        n_err++;
                        $display("FAIL write: got en=%h addr=%0d data=%h, want en=%h addr=%0d data=%h",
                                 wr_en_o, wr_addr_o, wr_data_o, e.en, e.addr, e.data);
                    end
                end
                for (int s = 0; s < 4; s++) begin
                    if (wr_cnt == spot_idx[s]) begin
                        n_cmp++;
                        if (wr_en_o !== spot_en[s] || wr_addr_o !== spot_addr[s]) begin
                            n_err++;
                            $display("FAIL spot_beat_%0d: got en=%h addr=%0d, want en=%h addr=%0d",
                                     spot_idx[s], wr_en_o, wr_addr_o, spot_en[s], spot_addr[s]);
                        end
                    end
                end
                u = 0;
                for (int b = 0; b < DU; b++) begin
                    if (wr_en_o[b]) u = b;
                end
                if (img_sel == 1) img_a[u * 1024 + int'(wr_addr_o)] = wr_data_o;
                if (img_sel == 2) img_b[u * 1024 + int'(wr_addr_o)] = wr_data_o;
                wr_cnt++;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        wr_cnt  = 0;
        check1("start_busy_ready", {30'd0, busy_o, lut_ready_o}, 32'd3);
    endtask

    // Drive n beats (data = beat index) with gap% idle cycles; optionally pulse start_i with beat pulse_at.
    task automatic send(input int n, input int gap, input int pulse_at);
        int idx;
        int budget;
        idx    = 0;
        budget = 0;
        while (idx < n) begin
            lut_valid_i = (gap == 0) ? 1'b1 : (int'($urandom_range(99)) >= gap);
            lut_data_i  = DW'(idx);
            start_i     = (idx == pulse_at) && lut_valid_i;
            @(negedge clk_i);
            if (lut_valid_i && lut_ready_o) begin
                sb_q.push_back(model(idx, DW'(idx)));
                last_acc = cyc;
                idx++;
            end
            @(posedge clk_i); #1;
            start_i = 1'b0;
            budget++;
            if (budget > 40000) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got %0d beats accepted, want %0d", idx, n);
                break;
            end
        end
        lut_valid_i = 1'b0;
    endtask

    initial begin
        int nmis;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        lut_valid_i = 1'b0;
        lut_data_i  = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check1("reset_ctrl", {29'd0, lut_ready_o, busy_o, done_o}, 32'd0);
        check1("reset_wr", {wr_en_o, 6'd0, wr_addr_o} | 32'(wr_data_o), 32'd0);
        check1("reset_checksum", checksum_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Partial load, then reset while still in LOAD.
        do_start();
        send(100, 0, -1);
        repeat (3) @(posedge clk_i);
        #1;
        check1("partial_drain", sb_q.size(), 32'd0);
        check1("partial_checksum", checksum_o, CK_100);
        check1("partial_still_busy", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        #2;
        check1("midreset_ctrl", {29'd0, lut_ready_o, busy_o, done_o}, 32'd0);
        check1("midreset_wr", {wr_en_o, 6'd0, wr_addr_o} | 32'(wr_data_o), 32'd0);
        check1("midreset_checksum", checksum_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Gap-free full load with a start pulse mid-load.
        done_cnt = 0;
        img_sel  = 1;
        do_start();
        send(TOTAL, 0, 5000);
        check1("full_busy_low_at_done", {31'd0, busy_o}, 32'd0);
        check1("full_checksum", checksum_o, CK_FULL);
        @(posedge clk_i); #1;
        check1("full_idle_after_done", {30'd0, busy_o, lut_ready_o}, 32'd0);
        check1("full_done_count", done_cnt, 32'd1);
        check1("full_done_cycle", done_cyc, last_acc + 1);

        // Restart immediately (two cycles after last beat), 50% gaps, start pulse during DONE.
        done_cnt = 0;
        img_sel  = 2;
        do_start();
        send(TOTAL, 50, -1);
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check1("start_in_done_ignored", {30'd0, busy_o, lut_ready_o}, 32'd0);
        check1("gap_done_count", done_cnt, 32'd1);
        check1("gap_done_cycle", done_cyc, last_acc + 1);
        check1("gap_checksum", checksum_o, CK_FULL);
        nmis = 0;
        for (int i = 0; i < TOTAL; i++) begin
            if (img_a[i] !== img_b[i]) nmis++;
        end
        check1("image_gap_vs_nogap", nmis, 32'd0);

        // Abort after 1000 beats with a beat presented on the abort cycle.
        done_cnt = 0;
        img_sel  = 0;
        do_start();
        send(1000, 0, -1);
        lut_valid_i = 1'b1;
        lut_data_i  = 16'd1000;
        abort_i     = 1'b1;
        @(negedge clk_i);
        check1("abort_ready_low", {31'd0, lut_ready_o}, 32'd0);
        @(posedge clk_i); #1;
        abort_i     = 1'b0;
        lut_valid_i = 1'b0;
        check1("abort_busy_low", {31'd0, busy_o}, 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check1("abort_no_done", done_cnt, 32'd0);
        check1("abort_drain", sb_q.size(), 32'd0);
        do_start();
        send(1, 0, -1);
        repeat (2) @(posedge clk_i);
        #1;
        check1("final_drain", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
